// File: rtl/psl_cmd_sched.sv
// Shares one AFU->PSL command port among NREQ requesters: round-robin grant, tag allocation,
// credit accounting and response routing. Define PSL_CMD_PARITY_EN for odd-parity outputs.
module psl_cmd_sched #(
    parameter int NREQ  = 4,
    parameter int NTAGS = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [13*NREQ-1:0] req_com,
    input  logic [64*NREQ-1:0] req_ea,
    input  logic [12*NREQ-1:0] req_size,
    output logic [NREQ-1:0]    req_ready,
    output logic [7:0]         req_tag,
    output logic               ah_cvalid,
    output logic [7:0]         ah_ctag,
    output logic               ah_ctagpar,
    output logic [12:0]        ah_com,
    output logic               ah_compar,
    output logic [2:0]         ah_cabt,
    output logic [63:0]        ah_cea,
    output logic               ah_ceapar,
    output logic [15:0]        ah_cch,
    output logic [11:0]        ah_csize,
    input  logic [7:0]         ha_croom,
    input  logic               ha_rvalid,
    input  logic [7:0]         ha_rtag,
    input  logic [7:0]         ha_response,
    input  logic [8:0]         ha_rcredits,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [7:0]         rsp_tag,
    output logic [7:0]         rsp_code,
    output logic [8:0]         outstanding,
    output logic               err_tag
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [NTAGS-1:0]  r_busy;
    logic [IW-1:0]     r_owner [NTAGS];
    logic signed [9:0] r_credits;
    logic [IW-1:0]     r_rr_ptr;
    logic              r_err_tag;
    logic              r_cvalid;
    logic [7:0]        r_ctag;
    logic [12:0]       r_com;
    logic [63:0]       r_cea;
    logic [11:0]       r_csize;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [7:0]        r_rsp_tag;
    logic [7:0]        r_rsp_code;
    logic [8:0]        r_outstanding;

    logic              w_tag_free;
    logic [7:0]        w_free_tag;
    logic              w_found;
    logic [IW-1:0]     w_winner;
    logic [IW-1:0]     w_idx;
    logic              w_grant;
    logic [NREQ-1:0]   w_ready;
    logic [12:0]       w_com;
    logic [63:0]       w_ea;
    logic [11:0]       w_size;
    logic              w_rsp_hit;
    logic [IW-1:0]     w_rsp_owner;
    logic [NREQ-1:0]   w_rsp_onehot;
    logic [NTAGS-1:0]  w_busy_next;
    logic [11:0]       w_cred_sum;
    logic [9:0]        w_cred_next;

    always_comb begin
        w_tag_free = 1'b0;
        w_free_tag = '0;
        for (int t = NTAGS - 1; t >= 0; t--) begin
            if (!r_busy[t]) begin
                w_tag_free = 1'b1;
                w_free_tag = 8'(t);
            end
        end

        // Round-robin search starting at r_rr_ptr, wrapping modulo NREQ.
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end

        w_grant = (r_state == ST_RUN) && !r_credits[9] && (r_credits != '0) &&
                  w_tag_free && w_found;

        w_ready = '0;
        w_com   = '0;
        w_ea    = '0;
        w_size  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == IW'(i)) begin
                w_ready[i] = w_grant;
                w_com      = req_com[13*i +: 13];
                w_ea       = req_ea[64*i +: 64];
                w_size     = req_size[12*i +: 12];
            end
        end
    end

    always_comb begin
        w_rsp_hit   = 1'b0;
        w_rsp_owner = '0;
        for (int t = 0; t < NTAGS; t++) begin
            if (ha_rvalid && (ha_rtag == 8'(t)) && r_busy[t]) begin
                w_rsp_hit   = 1'b1;
                w_rsp_owner = r_owner[t];
            end
        end

        w_rsp_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rsp_onehot[i] = w_rsp_hit && (w_rsp_owner == IW'(i));
        end

        // A tag freed this cycle stays busy for the allocator until the next cycle.
        for (int t = 0; t < NTAGS; t++) begin
            w_busy_next[t] = (r_busy[t] | (w_grant && (w_free_tag == 8'(t)))) &
                             ~(w_rsp_hit && (ha_rtag == 8'(t)));
        end

        w_cred_sum = {{2{r_credits[9]}}, r_credits} - {11'd0, w_grant} +
                     {{3{ha_rcredits[8]}}, ha_rcredits};
        if (w_cred_sum[11]) begin
            w_cred_next = '0;
        end else if (w_cred_sum[10:9] != 2'b00) begin
            w_cred_next = 10'd511;
        end else begin
            w_cred_next = w_cred_sum[9:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= ST_INIT;
            r_busy        <= '0;
            r_credits     <= '0;
            r_rr_ptr      <= '0;
            r_err_tag     <= 1'b0;
            r_cvalid      <= 1'b0;
            r_ctag        <= '0;
            r_com         <= '0;
            r_cea         <= '0;
            r_csize       <= '0;
            r_rsp_valid   <= '0;
            r_rsp_tag     <= '0;
            r_rsp_code    <= '0;
            r_outstanding <= '0;
            for (int t = 0; t < NTAGS; t++) begin
                r_owner[t] <= '0;
            end
        end else begin
            if (r_state == ST_INIT) begin
                r_state   <= ST_RUN;
                r_credits <= {2'b00, ha_croom};
            end else begin
                r_credits <= w_cred_next;
            end

            r_busy        <= w_busy_next;
            r_outstanding <= r_outstanding + {8'd0, w_grant} - {8'd0, w_rsp_hit};

            r_cvalid <= w_grant;
            if (w_grant) begin
                r_ctag   <= w_free_tag;
                r_com    <= w_com;
                r_cea    <= w_ea;
                r_csize  <= w_size;
                r_rr_ptr <= (w_winner == IW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
                for (int t = 0; t < NTAGS; t++) begin
                    if (w_free_tag == 8'(t)) begin
                        r_owner[t] <= w_winner;
                    end
                end
            end

            r_rsp_valid <= w_rsp_onehot;
            if (w_rsp_hit) begin
                r_rsp_tag  <= ha_rtag;
                r_rsp_code <= ha_response;
            end
            if (ha_rvalid && !w_rsp_hit) begin
                r_err_tag <= 1'b1;
            end
        end
    end

`ifdef PSL_CMD_PARITY_EN
    logic r_ctagpar;
    logic r_compar;
    logic r_ceapar;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ctagpar <= 1'b0;
            r_compar  <= 1'b0;
            r_ceapar  <= 1'b0;
        end else if (w_grant) begin
            r_ctagpar <= ~^w_free_tag;
            r_compar  <= ~^w_com;
            r_ceapar  <= ~^w_ea;
        end
    end

    assign ah_ctagpar = r_ctagpar;
    assign ah_compar  = r_compar;
    assign ah_ceapar  = r_ceapar;
`else
    assign ah_ctagpar = 1'b0;
    assign ah_compar  = 1'b0;
    assign ah_ceapar  = 1'b0;
`endif

    assign req_ready   = w_ready;
    assign req_tag     = w_grant ? w_free_tag : 8'd0;
    assign ah_cvalid   = r_cvalid;
    assign ah_ctag     = r_ctag;
    assign ah_com      = r_com;
    assign ah_cabt     = 3'b000;
    assign ah_cea      = r_cea;
    assign ah_cch      = 16'd0;
    assign ah_csize    = r_csize;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_tag     = r_rsp_tag;
    assign rsp_code    = r_rsp_code;
    assign outstanding = r_outstanding;
    assign err_tag     = r_err_tag;

endmodule

// File: tb/tb_psl_cmd_sched.sv
// Randomized bench for psl_cmd_sched against a cycle-level reference model built from
// tag sets, integer credits and a round-robin pointer.
module tb_psl_cmd_sched;

    localparam int NREQ  = 4;
    localparam int NTAGS = 8;

    logic                CLK;
    logic                RST;
    logic [NREQ-1:0]     req_valid;
    logic [13*NREQ-1:0]  req_com;
    logic [64*NREQ-1:0]  req_ea;
    logic [12*NREQ-1:0]  req_size;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          req_tag;
    logic                ah_cvalid;
    logic [7:0]          ah_ctag;
    logic                ah_ctagpar;
    logic [12:0]         ah_com;
    logic                ah_compar;
    logic [2:0]          ah_cabt;
    logic [63:0]         ah_cea;
    logic                ah_ceapar;
    logic [15:0]         ah_cch;
    logic [11:0]         ah_csize;
    logic [7:0]          ha_croom;
    logic                ha_rvalid;
    logic [7:0]          ha_rtag;
    logic [7:0]          ha_response;
    logic [8:0]          ha_rcredits;
    logic [NREQ-1:0]     rsp_valid;
    logic [7:0]          rsp_tag;
    logic [7:0]          rsp_code;
    logic [8:0]          outstanding;
    logic                err_tag;

    psl_cmd_sched #(.NREQ(NREQ), .NTAGS(NTAGS)) u_dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_com(req_com), .req_ea(req_ea), .req_size(req_size),
        .req_ready(req_ready), .req_tag(req_tag),
        .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar), .ah_com(ah_com),
        .ah_compar(ah_compar), .ah_cabt(ah_cabt), .ah_cea(ah_cea), .ah_ceapar(ah_ceapar),
        .ah_cch(ah_cch), .ah_csize(ah_csize),
        .ha_croom(ha_croom), .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag),
        .ha_response(ha_response), .ha_rcredits(ha_rcredits),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_code(rsp_code),
        .outstanding(outstanding), .err_tag(err_tag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    bit          m_busy [NTAGS];
    int          m_owner[NTAGS];
    int          m_cred;
    int          m_rr;
    bit          m_run;
    bit          m_err;
    bit          m_was_rst;
    bit          e_cvalid;
    logic [7:0]  e_ctag;
    logic [12:0] e_com;
    logic [63:0] e_ea;
    logic [11:0] e_size;
    logic [NREQ-1:0] e_rsp_valid;
    logic [7:0]  e_rsp_tag;
    logic [7:0]  e_rsp_code;
    int          e_out;

    // Stimulus knobs.
    int  k_vmode, k_vmask, k_rsp_pct, k_bad_pct, k_cred_mode, k_rst_pct;
    bit  k_in_reset;
    int  grant_count;

    task automatic model_reset();
        for (int t = 0; t < NTAGS; t++) begin
            m_busy[t]  = 1'b0;
            m_owner[t] = 0;
        end
        m_cred = 0; m_rr = 0; m_run = 1'b0; m_err = 1'b0;
        e_cvalid = 1'b0; e_ctag = '0; e_com = '0; e_ea = '0; e_size = '0;
        e_rsp_valid = '0; e_rsp_tag = '0; e_rsp_code = '0; e_out = 0;
    endtask

    task automatic model_grant(output bit g, output int who, output int tag);
        int free_t;
        g = 1'b0; who = 0; tag = 0; free_t = -1;
        if (!m_run || m_cred < 1) return;
        for (int t = NTAGS - 1; t >= 0; t--) if (!m_busy[t]) free_t = t;
        if (free_t < 0) return;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (req_valid[i]) begin
                g = 1'b1; who = i; tag = free_t;
                return;
            end
        end
    endtask

    task automatic model_edge();
        bit g;
        int who, tag, cnt;
        bit hit;
        m_was_rst = RST;
        if (RST) begin
            model_reset();
            return;
        end
        model_grant(g, who, tag);
        hit = ha_rvalid && (int'(ha_rtag) < NTAGS) && m_busy[int'(ha_rtag) % NTAGS];
        e_cvalid = g;
        if (g) begin
            e_ctag = 8'(tag);
            e_com  = req_com[13*who +: 13];
            e_ea   = req_ea[64*who +: 64];
            e_size = req_size[12*who +: 12];
        end
        e_rsp_valid = '0;
        if (hit) begin
            e_rsp_valid = NREQ'(1) << m_owner[ha_rtag];
            e_rsp_tag   = ha_rtag;
            e_rsp_code  = ha_response;
            m_busy[ha_rtag] = 1'b0;
        end else if (ha_rvalid) begin
            m_err = 1'b1;
        end
        if (!m_run) begin
            m_cred = int'(ha_croom);
            m_run  = 1'b1;
        end else begin
            m_cred = m_cred - int'(g) + int'($signed(ha_rcredits));
            if (m_cred < 0)   m_cred = 0;
            if (m_cred > 511) m_cred = 511;
        end
        if (g) begin
            m_busy[tag]  = 1'b1;
            m_owner[tag] = who;
            m_rr = (who + 1) % NREQ;
            grant_count++;
        end
        cnt = 0;
        for (int t = 0; t < NTAGS; t++) cnt += int'(m_busy[t]);
        e_out = cnt;
    endtask

    task automatic check_regs();
        logic tagpar_exp, compar_exp, eapar_exp;
`ifdef PSL_CMD_PARITY_EN
        tagpar_exp = ~^e_ctag; compar_exp = ~^e_com; eapar_exp = ~^e_ea;
`else
        tagpar_exp = 1'b0; compar_exp = 1'b0; eapar_exp = 1'b0;
`endif
        if (m_was_rst) begin
            tagpar_exp = 1'b0; compar_exp = 1'b0; eapar_exp = 1'b0;
        end
        check_eq("ah_cvalid", ah_cvalid, e_cvalid);
        if (e_cvalid || m_was_rst) begin
            check_eq("ah_ctag", ah_ctag, e_ctag);
            check_eq("ah_com", ah_com, e_com);
            check_eq("ah_cea", ah_cea, e_ea);
            check_eq("ah_csize", ah_csize, e_size);
            check_eq("ah_ctagpar", ah_ctagpar, tagpar_exp);
            check_eq("ah_compar", ah_compar, compar_exp);
            check_eq("ah_ceapar", ah_ceapar, eapar_exp);
        end
        check_eq("rsp_valid", rsp_valid, e_rsp_valid);
        if (e_rsp_valid != '0 || m_was_rst) begin
            check_eq("rsp_tag", rsp_tag, e_rsp_tag);
            check_eq("rsp_code", rsp_code, e_rsp_code);
        end
        check_eq("outstanding", outstanding, 64'(e_out));
        check_eq("err_tag", err_tag, m_err);
    endtask

    task automatic check_comb();
        bit g;
        int who, tag;
        model_grant(g, who, tag);
        check_eq("req_ready", req_ready, g ? (NREQ'(1) << who) : NREQ'(0));
        if (g) check_eq("req_tag", req_tag, 64'(tag));
    endtask

    task automatic drive_inputs();
        int busy_q[$];
        RST = k_in_reset || (($urandom % 1000) < k_rst_pct);
        case (k_vmode)
            0:       req_valid = '1;
            1:       req_valid = NREQ'($urandom) & NREQ'(k_vmask);
            default: req_valid = NREQ'(k_vmask);
        endcase
        for (int i = 0; i < NREQ; i++) begin
            req_com[13*i +: 13]  = 13'($urandom);
            req_ea[64*i +: 64]   = {$urandom, $urandom};
            req_size[12*i +: 12] = 12'($urandom);
        end
        ha_rvalid   = 1'b0;
        ha_rtag     = '0;
        ha_response = 8'($urandom);
        ha_rcredits = '0;
        if (($urandom % 100) < k_rsp_pct) begin
            ha_rvalid = 1'b1;
            for (int t = 0; t < NTAGS; t++) if (m_busy[t]) busy_q.push_back(t);
            if (busy_q.size() == 0 || ($urandom % 100) < k_bad_pct)
                ha_rtag = 8'($urandom_range(0, 31));
            else
                ha_rtag = 8'(busy_q[$urandom % busy_q.size()]);
        end
        case (k_cred_mode)
            1:       ha_rcredits = ha_rvalid ? 9'd1 : 9'd0;
            2:       ha_rcredits = 9'($signed($urandom_range(0, 4)) - 2);
            3:       ha_rcredits = 9'($urandom);
            default: ha_rcredits = 9'd0;
        endcase
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check_regs();
        drive_inputs();
        #1;
        check_comb();
    endtask

    task automatic run_phase(input int croom, input int vmode, input int vmask, input int rsp_pct,
                             input int bad_pct, input int cred_mode, input int rst_pct,
                             input int ncycles);
        k_in_reset = 1'b1;
        k_rst_pct = 0; k_rsp_pct = 0;
        ha_croom = 8'(croom);
        k_vmode = vmode; k_vmask = vmask; k_bad_pct = bad_pct; k_cred_mode = cred_mode;
        drive_inputs();
        cycle();
        cycle();
        k_in_reset = 1'b0;
        k_rsp_pct  = rsp_pct;
        k_rst_pct  = rst_pct;
        grant_count = 0;
        for (int c = 0; c < ncycles; c++) cycle();
    endtask

    initial begin
        RST = 1'b1;
        req_valid = '0; req_com = '0; req_ea = '0; req_size = '0;
        ha_croom = 8'd8; ha_rvalid = 1'b0; ha_rtag = '0; ha_response = '0; ha_rcredits = '0;
        model_reset();
        m_was_rst = 1'b1;

        // All requesters valid, eight credits, no responses: eight grants, then stall.
        run_phase(8, 0, 'hF, 0, 0, 0, 0, 16);
        check_eq("tp1_grants", 64'(grant_count), 64'd8);
        check_eq("tp1_outstanding", outstanding, 64'd8);
        check_eq("ah_cabt", ah_cabt, 64'd0);
        check_eq("ah_cch", ah_cch, 64'd0);

        run_phase(2, 1, 'hF, 30, 0, 1, 0, 200);
        run_phase(64, 2, 'h4, 15, 0, 0, 0, 200);
        run_phase(1, 1, 'hF, 40, 0, 2, 0, 300);
        run_phase(4, 1, 'hF, 25, 20, 1, 0, 200);
        check_eq("err_sticky", err_tag, 64'd1);
        run_phase(255, 1, 'hF, 50, 5, 3, 0, 500);
        run_phase(0, 1, 'hF, 30, 5, 2, 0, 200);
        run_phase(int'($urandom_range(1, 20)), 1, 'hF, 35, 5, 2, 20, 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
